ifetch_req: RTL and testbench

Instruction-request stage sitting directly upstream of `fetch`. It owns the sequential PC, drives the instruction bus with a request/response handshake, and buffers the returned word. It presents the word to `fetch` as `instruction` / `pc_nxt` qualified by `fetch_enable`. Redirects from branch/jump resolution cancel or discard in-flight traffic.

---
 rtl/ifetch_req.sv | 127 ++++++++++++
 tb/tb_ifetch_req.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_req.sv
// Instruction-request stage: owns the sequential PC, issues one bus request at a time
// and holds the returned word for fetch. Define IFETCH_ALIGN_CHECK_EN to trap misaligned PCs.
module ifetch_req #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    output logic [31:0] instruction,
    output logic [31:0] pc_nxt,
    output logic        fetch_enable,
    output logic        misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        discard_q, discard_d;
    logic        misalign_q, misalign_d;
    logic        bad_pc;
    logic        req_fire;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign bad_pc    = (pc_q[1:0] != 2'b00);
    assign ireq_addr = (state_q == S_REQ) ? pc_q : 32'h0;
`else
    assign bad_pc    = 1'b0;
    assign ireq_addr = (state_q == S_REQ) ? {pc_q[31:2], 2'b00} : 32'h0;
`endif

    // Outputs decode from state registers only; no input reaches an output combinationally.
    assign ireq_valid   = (state_q == S_REQ) && !bad_pc;
    assign fetch_enable = (state_q == S_HOLD);
    assign instruction  = (state_q == S_HOLD) ? buf_q : 32'h0;
    assign pc_nxt       = (state_q == S_HOLD) ? pc_q  : 32'h0;
    assign misalign     = misalign_q;

    assign req_fire = ireq_valid && ireq_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        discard_d  = discard_q;
        misalign_d = misalign_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect) pc_d = redirect_pc;
                else          state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    // An address accepted this very cycle is already stale.
                    if (req_fire) begin
                        discard_d = 1'b1;
                        state_d   = S_WAIT;
                    end
                end else if (bad_pc) begin
                    buf_d      = 32'h0;
                    misalign_d = 1'b1;
                    state_d    = S_HOLD;
                end else if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (iresp_valid) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (iresp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        buf_d   = iresp_data;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    buf_d      = 32'h0;
                    misalign_d = 1'b0;
                    state_d    = S_REQ;
                end else if (!stall) begin
                    pc_d       = pc_q + 32'd4;
                    misalign_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            buf_q      <= 32'h0;
            discard_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            discard_q  <= discard_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_ifetch_req.sv
// Directed bench for ifetch_req: inputs change 1 time unit after each rising edge,
// outputs are checked at that same point, reflecting the state just registered.
module tb_ifetch_req;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready = 1'b0;
    logic        iresp_valid = 1'b0;
    logic [31:0] iresp_data = 32'h0;
    logic [31:0] instruction;
    logic [31:0] pc_nxt;
    logic        fetch_enable;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_req #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .resetn(resetn), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .ireq_ready(ireq_ready), .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .instruction(instruction), .pc_nxt(pc_nxt), .fetch_enable(fetch_enable),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: valid/addr on the bus side, enable/instr/pc on the fetch side.
    task automatic chk_all(input string tag, input logic v, input logic [31:0] a,
                           input logic fe, input logic [31:0] ins, input logic [31:0] pc,
                           input logic mis);
        chk({tag, ".ireq_valid"},   {31'h0, ireq_valid},   {31'h0, v});
        chk({tag, ".ireq_addr"},    ireq_addr,             a);
        chk({tag, ".fetch_enable"}, {31'h0, fetch_enable}, {31'h0, fe});
        chk({tag, ".instruction"},  instruction,           ins);
        chk({tag, ".pc_nxt"},       pc_nxt,                pc);
        chk({tag, ".misalign"},     {31'h0, misalign},     {31'h0, mis});
    endtask

    initial begin
        #2 resetn = 1'b0;
        tick(); tick();
        chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        resetn = 1'b1;

        // Sequential fetch with ready=1 and one-cycle response.
        tick();
        chk_all("req0", 1, 32'h0, 0, 32'h0, 32'h0, 0);
        ireq_ready = 1'b1;
        tick();
        chk_all("wait0", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'h2408_0001;
        tick();
        chk_all("hold0", 0, 32'h0, 1, 32'h2408_0001, 32'h0, 0);
        iresp_valid = 1'b0;
        tick();
        chk_all("req4", 1, 32'h4, 0, 32'h0, 32'h0, 0);
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'h2409_0002;
        tick();
        chk_all("hold4", 0, 32'h0, 1, 32'h2409_0002, 32'h4, 0);
        iresp_valid = 1'b0;

        // Stall holds the word for 5 cycles.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("stall", 0, 32'h0, 1, 32'h2409_0002, 32'h4, 0);
        end
        stall = 1'b0;
        tick();
        chk_all("req8", 1, 32'h8, 0, 32'h0, 32'h0, 0);

        // Redirect while the request for 0x8 is outstanding.
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        chk_all("redir_wait", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        redirect = 1'b0; iresp_valid = 1'b1; iresp_data = 32'hDEAD_BEEF;
        tick();
        chk_all("discard", 1, 32'h100, 0, 32'h0, 32'h0, 0);
        iresp_valid = 1'b0;

        // Redirect coincident with the response.
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'h1111_1111;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        chk_all("redir_resp", 1, 32'h200, 0, 32'h0, 32'h0, 0);
        redirect = 1'b0; iresp_valid = 1'b0;
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'hAAAA_5555;
        tick();
        chk_all("hold200", 0, 32'h0, 1, 32'hAAAA_5555, 32'h200, 0);
        iresp_valid = 1'b0;

        // Redirect in HOLD wins over stall; then wrap past the top of memory.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk_all("redir_hold", 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
        stall = 1'b0; redirect = 1'b0; ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'h1234_5678;
        tick();
        chk_all("hold_top", 0, 32'h0, 1, 32'h1234_5678, 32'hFFFF_FFFC, 0);
        iresp_valid = 1'b0;
        tick();
        chk_all("wrap", 1, 32'h0, 0, 32'h0, 32'h0, 0);

        // Redirect in REQ in the same cycle the address is accepted.
        redirect = 1'b1; redirect_pc = 32'h0000_0300; ireq_ready = 1'b1;
        tick();
        chk_all("redir_acc", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        redirect = 1'b0; ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'h5A5A_5A5A;
        tick();
        chk_all("stale_drop", 1, 32'h300, 0, 32'h0, 32'h0, 0);
        iresp_valid = 1'b0;

        // Misaligned redirect target.
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        chk_all("mis_req", 0, 32'h102, 0, 32'h0, 32'h0, 0);
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0;
        chk_all("mis_hold", 0, 32'h0, 1, 32'h0, 32'h102, 1);
        tick();
        chk_all("mis_left", 0, 32'h106, 0, 32'h0, 32'h0, 0);
        redirect = 1'b1; redirect_pc = 32'h0000_0000;
        tick();
        redirect = 1'b0;
`else
        chk_all("mis_req", 1, 32'h100, 0, 32'h0, 32'h0, 0);
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0; iresp_valid = 1'b1; iresp_data = 32'h0BAD_F00D;
        tick();
        iresp_valid = 1'b0;
        chk_all("mis_hold", 0, 32'h0, 1, 32'h0BAD_F00D, 32'h102, 0);
        redirect = 1'b1; redirect_pc = 32'h0000_0000;
        tick();
        redirect = 1'b0;
`endif

        // Reset mid-transaction; a late response must be ignored afterwards.
        ireq_ready = 1'b1;
        tick();
        ireq_ready = 1'b0;
        resetn = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'h0, 0, 32'h0, 32'h0, 0);
        tick();
        resetn = 1'b1; iresp_valid = 1'b1; iresp_data = 32'h7777_7777;
        tick();
        chk_all("rst_req", 1, 32'h0, 0, 32'h0, 32'h0, 0);
        tick();
        chk_all("rst_ignore", 1, 32'h0, 0, 32'h0, 32'h0, 0);
        iresp_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
